mem_readback: RTL and testbench

Sequential readback engine for the MIPS FPU CPU's word-addressed memory. After a program run it streams a block of memory words (for example, floating-point results stored by the CPU) out over a valid/ready interface and keeps a running checksum. It is the reader counterpart to the program/data loader. It sits beside the CPU on a dedicated synchronous read port of the memory and feeds a debug/host sink.

---
 rtl/mem_readback.sv | 161 ++++++++++++++++
 tb/tb_mem_readback.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback.sv
// Streams a block of words from a 1-cycle-latency synchronous memory port out over
// valid/ready, keeping a running checksum of the accepted words.
module mem_readback #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]          count_q, count_d;
    logic [ADDR_WIDTH-1:0]          issued_q, issued_d;
    logic                           inflight_q, inflight_d;
    logic                           inf_last_q, inf_last_d;
    logic [ADDR_WIDTH-1:0]          inf_addr_q, inf_addr_d;
    logic [1:0][DATA_WIDTH-1:0]     fdata_q, fdata_d;
    logic [1:0][ADDR_WIDTH-1:0]     faddr_q, faddr_d;
    logic [1:0]                     flast_q, flast_d;
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    logic [1:0]                     fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0]          csum_q, csum_d;

    logic       fifo_valid;
    logic       pop;
    logic       issue_last;
    logic [1:0] occ;

    // Occupancy counts the slot freed by a pop on this edge, which keeps one word per
    // cycle flowing while never holding more than two words after the edge.
    always_comb begin
        fifo_valid = (fcnt_q != 2'd0);
        pop        = fifo_valid && out_ready;
        occ        = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
        issue_last = (issued_q == count_q - ONE_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (word_count == '0) ? DONE : READ;
            READ:    if (mem_rd_en && issue_last) state_d = DRAIN;
            DRAIN:   if (pop && out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        mem_rd_en = (state_q == READ) && (occ < 2'd2);
        mem_addr  = addr_q;
        out_valid = fifo_valid;
        out_data  = fifo_valid ? fdata_q[rd_ptr_q] : '0;
        out_addr  = fifo_valid ? faddr_q[rd_ptr_q] : '0;
        out_last  = fifo_valid && flast_q[rd_ptr_q];
        checksum  = csum_q;
    end

    always_comb begin
        addr_d     = addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        inf_addr_d = inf_addr_q;
        inf_last_d = inf_last_q;
        fdata_d    = fdata_q;
        faddr_d    = faddr_q;
        flast_d    = flast_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        csum_d     = csum_q;
        inflight_d = mem_rd_en;

        if (state_q == IDLE && start) begin
            addr_d   = base_addr;
            count_d  = word_count;
            issued_d = '0;
            csum_d   = '0;
        end
        if (mem_rd_en) begin
            addr_d     = addr_q + ONE_A;
            issued_d   = issued_q + ONE_A;
            inf_addr_d = addr_q;
            inf_last_d = issue_last;
        end
        // Read data is only meaningful the cycle after the strobe; capture it then.
        if (inflight_q) begin
            fdata_d[wr_ptr_q] = mem_rdata;
            faddr_d[wr_ptr_q] = inf_addr_q;
            flast_d[wr_ptr_q] = inf_last_q;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            csum_d   = csum_q + out_data;
        end
        fcnt_d = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            inf_addr_q <= '0;
            inf_last_q <= 1'b0;
            fdata_q    <= '0;
            faddr_q    <= '0;
            flast_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fcnt_q     <= '0;
            csum_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            inf_addr_q <= inf_addr_d;
            inf_last_q <= inf_last_d;
            fdata_q    <= fdata_d;
            faddr_q    <= faddr_d;
            flast_q    <= flast_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// Randomized scoreboard bench for mem_readback: a driver queues the expected beats of
// each run from a memory array; a negedge monitor checks beats, reads, stalls and done.
module tb_mem_readback;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, done, mem_rd_en, out_valid, out_last;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] out_data, checksum;

    logic [DW-1:0] mem [0:65535];

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [AW-1:0] cur_base = '0;
    int            cur_count = 0;
    int            issued_cnt = 0;
    int            accepted = 0;
    int            beats_seen = 0;
    logic [DW-1:0] csum_exp = '0;
    logic          done_due = 1'b0;
    logic          held = 1'b0;
    logic [DW+AW:0] held_v = '0;
    logic [5:0]    ready_pat = 6'b101001;

    mem_readback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t         e;
        logic          due_next;
        logic          pop_now;
        logic [AW-1:0] ea;
        int            outstanding;
        if (rst_n) begin
            due_next = 1'b0;
            pop_now  = out_valid && out_ready;
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_fields", 64'({out_data, out_addr, out_last}), 64'(held_v));
                held = 1'b0;
            end
            if (mem_rd_en) begin
                ea = cur_base + AW'(issued_cnt);
                chk("rd_addr", 64'(mem_addr), 64'(ea));
                chk("rd_budget", 64'(issued_cnt < cur_count), 64'd1);
                outstanding = issued_cnt - accepted - (pop_now ? 1 : 0);
                chk("rd_outstanding", 64'(outstanding < 2), 64'd1);
                issued_cnt++;
            end
            if (done || done_due) chk("done_pulse", 64'(done), 64'(done_due));
            if (out_valid) begin
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(out_data), 64'(e.d));
                        chk("beat_addr", 64'(out_addr), 64'(e.a));
                        chk("beat_last", 64'(out_last), 64'(e.l));
                        csum_exp = csum_exp + e.d;
                        accepted++;
                        beats_seen++;
                        due_next = e.l;
                    end
                end else begin
                    held   = 1'b1;
                    held_v = {out_data, out_addr, out_last};
                end
            end
            done_due = due_next;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    task automatic set_ready(input int mode, input int cyc);
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ready_pat[cyc % 6];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_run(input logic [AW-1:0] base, input int count);
        beat_t b;
        cur_base   = base;
        cur_count  = count;
        issued_cnt = 0;
        accepted   = 0;
        beats_seen = 0;
        csum_exp   = '0;
        for (int i = 0; i < count; i++) begin
            b.a = base + AW'(i);
            b.d = mem[b.a];
            b.l = (i == count - 1);
            exp_q.push_back(b);
        end
        start      = 1'b1;
        base_addr  = base;
        word_count = AW'(count);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (count == 0) begin
            done_due = 1'b1;
        end else begin
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_rd_en", 64'(mem_rd_en), 64'd1);
            chk("start_mem_addr", 64'(mem_addr), 64'(base));
            chk("start_no_valid", 64'(out_valid), 64'd0);
        end
    endtask

    task automatic run(input logic [AW-1:0] base, input int count, input int mode, input bit inject);
        set_ready(mode, 0);
        start_run(base, count);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) break;
            @(posedge clk);
            #1;
            set_ready(mode, cyc + 1);
            if (inject && cyc == 3) begin
                start      = 1'b1;
                base_addr  = '0;
                word_count = AW'(7);
            end
            if (cyc == 4) start = 1'b0;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("checksum", 64'(checksum), 64'(csum_exp));
        chk("all_beats", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h2008] = 32'hc5aff000;
        mem[16'h2009] = 32'h402ccccd;
        mem[16'h200A] = 32'h4611d54a;
        mem[16'h200B] = 32'hc257da1d;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(16'h2008, 4, 0, 1'b0);
        run(16'h2008, 4, 1, 1'b0);
        run(16'h2008, 0, 0, 1'b0);
        run(16'hFFFE, 4, 0, 1'b0);
        run(16'h4000, 8, 0, 1'b1);

        // Abort an 8-word run after two beats, then expect a clean fresh run.
        set_ready(0, 0);
        start_run(16'h3000, 8);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (beats_seen >= 2) break;
            @(posedge clk);
            #1;
        end
        chk("abort_two_beats", 64'(beats_seen >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        exp_q.delete();
        held      = 1'b0;
        done_due  = 1'b0;
        cur_count = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(16'h3100, 8, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run(AW'($urandom), int'($urandom_range(1, 20)), 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
